// File: rtl/keccak_rate_packer.sv
// Absorb front-end for the Keccak engine: packs tkeep-qualified byte beats into rate-sized
// blocks, carries overflow bytes into the next block and applies suffix + pad10*1 at the end.
module keccak_rate_packer #(
  parameter int DWIDTH     = 256,
  parameter int KEEP_WIDTH = DWIDTH / 8,
  parameter int MAX_RATE   = 1344,
  parameter int CNT_WIDTH  = $clog2(MAX_RATE / 8 + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [DWIDTH-1:0]     s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [MAX_RATE-1:0]   blk_data,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic                  blk_last,
  output logic                  busy_o
);

  localparam int RATE_BYTES = MAX_RATE / 8;
  localparam int SUM_W      = CNT_WIDTH + 1;
  localparam int SH_W       = $clog2(MAX_RATE + 1);
  localparam int N_W        = $clog2(KEEP_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_EMIT,
    S_PAD,
    S_EMIT_LAST
  } state_t;

  state_t                state_reg, state_next;
  logic [1:0]            mode_reg, mode_next;
  logic [MAX_RATE-1:0]   buf_reg, buf_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [DWIDTH-1:0]     carry_reg, carry_next;
  logic [N_W-1:0]        carry_cnt_reg, carry_cnt_next;
  logic                  pend_last_reg, pend_last_next;

  logic [CNT_WIDTH-1:0]  rate_bytes;
  logic [7:0]            suffix;
  logic [N_W-1:0]        keep_n;
  logic [SUM_W-1:0]      sum;
  logic [DWIDTH-1:0]     keep_bits;
  logic [DWIDTH-1:0]     data_masked;
  logic [MAX_RATE-1:0]   rate_mask;
  logic [SH_W-1:0]       fill_shift;
  logic [SH_W-1:0]       carry_shift;
  logic [SH_W-1:0]       last_shift;
  logic [MAX_RATE-1:0]   placed;
  logic [MAX_RATE-1:0]   pad_vec;

  always_comb begin
    rate_bytes = CNT_WIDTH'(136);
    suffix     = 8'h06;
    case (mode_reg)
      2'd0: begin rate_bytes = CNT_WIDTH'(136); suffix = 8'h06; end
      2'd1: begin rate_bytes = CNT_WIDTH'(72);  suffix = 8'h06; end
      2'd2: begin rate_bytes = CNT_WIDTH'(168); suffix = 8'h1F; end
      default: begin rate_bytes = CNT_WIDTH'(136); suffix = 8'h1F; end
    endcase
  end

  // Byte-granular masks: expanded tkeep for the beat, and bytes below the active rate.
  generate
    for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_keep
      assign keep_bits[gi*8 +: 8] = {8{s_tkeep[gi]}};
    end
    for (genvar gi = 0; gi < RATE_BYTES; gi++) begin : g_rate
      assign rate_mask[gi*8 +: 8] = {8{CNT_WIDTH'(gi) < rate_bytes}};
    end
  endgenerate

  always_comb begin
    keep_n = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      keep_n = keep_n + N_W'(s_tkeep[i]);
    end
  end

  assign data_masked = s_tdata & keep_bits;
  assign sum         = SUM_W'(cnt_reg) + SUM_W'(keep_n);
  assign fill_shift  = SH_W'(cnt_reg) << 3;
  assign carry_shift = SH_W'(rate_bytes - cnt_reg) << 3;
  assign last_shift  = SH_W'(rate_bytes - CNT_WIDTH'(1)) << 3;
  // Buffer bytes at and above cnt are always zero, so a plain OR merges the new beat in.
  assign placed      = (MAX_RATE'(data_masked) << fill_shift) & rate_mask;
  assign pad_vec     = (MAX_RATE'(suffix) << fill_shift) ^ (MAX_RATE'(8'h80) << last_shift);

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    buf_next       = buf_reg;
    cnt_next       = cnt_reg;
    carry_next     = carry_reg;
    carry_cnt_next = carry_cnt_reg;
    pend_last_next = pend_last_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          mode_next      = mode_i;
          buf_next       = '0;
          cnt_next       = '0;
          carry_next     = '0;
          carry_cnt_next = '0;
          pend_last_next = 1'b0;
          state_next     = S_FILL;
        end
      end
      S_FILL: begin
        if (s_tvalid) begin
          buf_next = buf_reg | placed;
          if (sum < SUM_W'(rate_bytes)) begin
            cnt_next = CNT_WIDTH'(sum);
            if (s_tlast) state_next = S_PAD;
          end else begin
            cnt_next       = rate_bytes;
            carry_next     = data_masked >> carry_shift;
            carry_cnt_next = N_W'(sum - SUM_W'(rate_bytes));
            pend_last_next = s_tlast;
            state_next     = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (blk_ready) begin
          buf_next       = MAX_RATE'(carry_reg);
          cnt_next       = CNT_WIDTH'(carry_cnt_reg);
          carry_next     = '0;
          carry_cnt_next = '0;
          state_next     = pend_last_reg ? S_PAD : S_FILL;
        end
      end
      S_PAD: begin
        buf_next   = buf_reg ^ pad_vec;
        state_next = S_EMIT_LAST;
      end
      S_EMIT_LAST: begin
        if (blk_ready) begin
          buf_next   = '0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      mode_reg      <= '0;
      buf_reg       <= '0;
      cnt_reg       <= '0;
      carry_reg     <= '0;
      carry_cnt_reg <= '0;
      pend_last_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      buf_reg       <= buf_next;
      cnt_reg       <= cnt_next;
      carry_reg     <= carry_next;
      carry_cnt_reg <= carry_cnt_next;
      pend_last_reg <= pend_last_next;
    end
  end

  assign s_tready  = (state_reg == S_FILL);
  assign blk_valid = (state_reg == S_EMIT) || (state_reg == S_EMIT_LAST);
  assign blk_last  = (state_reg == S_EMIT_LAST);
  assign busy_o    = (state_reg != S_IDLE);
  assign blk_data  = buf_reg;

endmodule

// File: tb/tb_keccak_rate_packer.sv
// Randomised bench for keccak_rate_packer; expected blocks come from a byte-level Keccak padding model.
module tb_keccak_rate_packer;
  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int MR = 1344;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [1:0]    mode_i = 2'd0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [MR-1:0] blk_data;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic          blk_last;
  logic          busy_o;

  keccak_rate_packer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_last(blk_last), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && s_tvalid && s_tready)
      assert (((s_tkeep + 1'b1) & s_tkeep) == '0) else $error("tkeep not contiguous");
  end

  int total = 0;
  int bad = 0;
  byte unsigned  msg_q[$];
  int            beat_q[$];
  logic [MR-1:0] got_blk[$];
  logic          got_last[$];
  logic [MR-1:0] exp_blk[$];
  logic          exp_last[$];
  logic [MR-1:0] stall_data_q[$];
  logic          stall_rdy_q[$];
  logic          stall_val_q[$];
  bit            timed_out;

  function automatic int rate_of(input logic [1:0] m);
    case (m)
      2'd0: return 136;
      2'd1: return 72;
      2'd2: return 168;
      default: return 136;
    endcase
  endfunction

  function automatic logic [7:0] sfx_of(input logic [1:0] m);
    return (m[1]) ? 8'h1F : 8'h06;
  endfunction

  function automatic int first_diff(input logic [MR-1:0] a, input logic [MR-1:0] b);
    for (int j = 0; j < MR / 8; j++)
      if (a[j*8 +: 8] !== b[j*8 +: 8]) return j;
    return -1;
  endfunction

  // Standard Keccak padding over the whole message, sliced into rate-sized blocks.
  task automatic build_model(input logic [1:0] mode);
    int rate, len, nblk, p;
    logic [7:0] v;
    logic [MR-1:0] blk;
    exp_blk.delete();
    exp_last.delete();
    rate = rate_of(mode);
    len  = msg_q.size();
    nblk = len / rate + 1;
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int i = 0; i < rate; i++) begin
        p = b * rate + i;
        v = (p < len) ? msg_q[p] : 8'h00;
        if (p == len) v = v ^ sfx_of(mode);
        if (b == nblk - 1 && i == rate - 1) v = v ^ 8'h80;
        blk[i*8 +: 8] = v;
      end
      exp_blk.push_back(blk);
      exp_last.push_back(b == nblk - 1);
    end
  endtask

  task automatic make_msg(input int len, input bit full_beats, input bit empty_tail);
    int left;
    int n;
    msg_q.delete();
    beat_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
    left = len;
    while (left > 0) begin
      n = full_beats ? KW : int'($urandom_range(1, KW));
      if (n > left) n = left;
      beat_q.push_back(n);
      left -= n;
    end
    if (len == 0 || empty_tail) beat_q.push_back(0);
  endtask

  task automatic start_msg(input logic [1:0] mode);
    @(posedge clk); #1;
    start_i = 1'b1;
    mode_i  = mode;
    @(posedge clk); #1;
    start_i = 1'b0;
    mode_i  = 2'($urandom);
  endtask

  // Drives the queued beats and collects every accepted block; no checking here.
  task automatic run_message(input logic [1:0] mode, input int gap_pct, input int rdy_pct,
                             input int stall_cycles);
    got_blk.delete();
    got_last.delete();
    stall_data_q.delete();
    stall_rdy_q.delete();
    stall_val_q.delete();
    timed_out = 1'b0;
    start_msg(mode);
    fork
      begin
        int off = 0;
        int guard = 0;
        bit acc;
        for (int b = 0; b < beat_q.size(); b++) begin
          while ($urandom_range(99) < gap_pct && !timed_out) begin
            s_tvalid = 1'b0;
            @(posedge clk); #1;
          end
          s_tvalid = 1'b1;
          s_tlast  = (b == beat_q.size() - 1);
          for (int k = 0; k < KW; k++) begin
            s_tdata[k*8 +: 8] = (k < beat_q[b]) ? msg_q[off + k] : 8'($urandom);
            s_tkeep[k]        = (k < beat_q[b]);
          end
          acc = 1'b0;
          while (!acc && !timed_out) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk); #1;
            guard++;
            if (guard > 5000) timed_out = 1'b1;
          end
          off += beat_q[b];
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tkeep  = '0;
      end
      begin
        bit done = 1'b0;
        int stall_left = stall_cycles;
        int cyc = 0;
        bit stalled;
        while (!done && !timed_out) begin
          stalled = blk_valid && stall_left > 0;
          if (stalled) begin
            blk_ready = 1'b0;
            stall_left--;
          end else begin
            blk_ready = ($urandom_range(99) < rdy_pct);
          end
          @(negedge clk);
          if (stalled) begin
            stall_data_q.push_back(blk_data);
            stall_rdy_q.push_back(s_tready);
            stall_val_q.push_back(blk_valid);
          end
          if (blk_valid && blk_ready) begin
            got_blk.push_back(blk_data);
            got_last.push_back(blk_last);
            if (blk_last) done = 1'b1;
          end
          cyc++;
          if (cyc > 5000) timed_out = 1'b1;
          @(posedge clk); #1;
        end
        blk_ready = 1'b0;
      end
    join
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy_o, s_tready, blk_valid, blk_last} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0000", {busy_o, s_tready, blk_valid, blk_last});
    end
    total++;
    if (blk_data !== '0) begin
      bad++;
      $display("FAIL reset_data byte%0d nonzero", first_diff(blk_data, '0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("reset: checked outputs");
  endtask

  task automatic test_empty;
    logic [MR-1:0] blk;
    make_msg(0, 1'b1, 1'b0);
    run_message(2'd0, 0, 100, 0);
    build_model(2'd0);
    total++;
    if (timed_out || got_blk.size() != 1) begin
      bad++;
      $display("FAIL empty_count got=%0d exp=1 timeout=%0b", got_blk.size(), timed_out);
    end
    blk = (got_blk.size() > 0) ? got_blk[0] : '0;
    total++;
    if (blk[7:0] !== 8'h06 || blk[135*8 +: 8] !== 8'h80) begin
      bad++;
      $display("FAIL empty_pad byte0=%h byte135=%h exp 06/80", blk[7:0], blk[135*8 +: 8]);
    end
    total++;
    if (blk !== exp_blk[0] || got_last.size() == 0 || got_last[0] !== 1'b1) begin
      bad++;
      $display("FAIL empty_block byte%0d differs", first_diff(blk, exp_blk[0]));
    end
    $display("sha3_256 empty: %0d block(s)", got_blk.size());
  endtask

  task automatic test_sha3_256_135;
    logic [MR-1:0] blk;
    make_msg(135, 1'b1, 1'b0);
    run_message(2'd0, 20, 100, 0);
    build_model(2'd0);
    total++;
    if (timed_out || got_blk.size() != 1) begin
      bad++;
      $display("FAIL s256_135_count got=%0d exp=1 timeout=%0b", got_blk.size(), timed_out);
    end
    blk = (got_blk.size() > 0) ? got_blk[0] : '0;
    total++;
    if (blk[134*8 +: 8] !== msg_q[134] || blk[135*8 +: 8] !== 8'h86) begin
      bad++;
      $display("FAIL s256_135_tail byte134=%h exp=%h byte135=%h exp=86",
               blk[134*8 +: 8], msg_q[134], blk[135*8 +: 8]);
    end
    total++;
    if (blk !== exp_blk[0] || got_last.size() == 0 || got_last[0] !== 1'b1) begin
      bad++;
      $display("FAIL s256_135_block byte%0d differs", first_diff(blk, exp_blk[0]));
    end
    $display("sha3_256 135B: %0d block(s)", got_blk.size());
  endtask

  task automatic test_sha3_512_96;
    make_msg(96, 1'b1, 1'b0);
    run_message(2'd1, 0, 70, 0);
    build_model(2'd1);
    total++;
    if (timed_out || got_blk.size() != 2) begin
      bad++;
      $display("FAIL s512_96_count got=%0d exp=2 timeout=%0b", got_blk.size(), timed_out);
    end
    for (int i = 0; i < got_blk.size() && i < 2; i++) begin
      total++;
      if (got_blk[i] !== exp_blk[i] || got_last[i] !== exp_last[i]) begin
        bad++;
        $display("FAIL s512_96_blk%0d byte%0d got=%h exp=%h last=%b exp=%b", i,
                 first_diff(got_blk[i], exp_blk[i]), got_blk[i][1023:0] ^ exp_blk[i][1023:0] ? 8'hxx : 8'h00,
                 8'h00, got_last[i], exp_last[i]);
      end
    end
    if (got_blk.size() == 2) begin
      total++;
      if (got_blk[1][24*8 +: 8] !== 8'h06 || got_blk[1][71*8 +: 8] !== 8'h80 ||
          got_blk[1][23*8 +: 8] !== msg_q[95]) begin
        bad++;
        $display("FAIL s512_96_pad byte23=%h exp=%h byte24=%h exp=06 byte71=%h exp=80",
                 got_blk[1][23*8 +: 8], msg_q[95], got_blk[1][24*8 +: 8], got_blk[1][71*8 +: 8]);
      end
    end
    $display("sha3_512 96B: %0d block(s)", got_blk.size());
  endtask

  task automatic test_shake128_168;
    make_msg(168, 1'b1, 1'b0);
    run_message(2'd2, 10, 80, 0);
    build_model(2'd2);
    total++;
    if (timed_out || got_blk.size() != 2) begin
      bad++;
      $display("FAIL sk128_168_count got=%0d exp=2 timeout=%0b", got_blk.size(), timed_out);
    end
    for (int i = 0; i < got_blk.size() && i < 2; i++) begin
      total++;
      if (got_blk[i] !== exp_blk[i] || got_last[i] !== exp_last[i]) begin
        bad++;
        $display("FAIL sk128_168_blk%0d byte%0d differs last=%b exp=%b", i,
                 first_diff(got_blk[i], exp_blk[i]), got_last[i], exp_last[i]);
      end
    end
    if (got_blk.size() == 2) begin
      total++;
      if (got_blk[1][7:0] !== 8'h1F || got_blk[1][167*8 +: 8] !== 8'h80) begin
        bad++;
        $display("FAIL sk128_168_pad byte0=%h exp=1f byte167=%h exp=80",
                 got_blk[1][7:0], got_blk[1][167*8 +: 8]);
      end
    end
    $display("shake128 168B: %0d block(s)", got_blk.size());
  endtask

  task automatic test_backpressure;
    make_msg(150, 1'b1, 1'b0);
    run_message(2'd1, 0, 100, 10);
    build_model(2'd1);
    total++;
    if (stall_data_q.size() != 10) begin
      bad++;
      $display("FAIL stall_len got=%0d exp=10", stall_data_q.size());
    end
    for (int i = 0; i < stall_data_q.size(); i++) begin
      total++;
      if (stall_data_q[i] !== exp_blk[0] || stall_rdy_q[i] !== 1'b0 || stall_val_q[i] !== 1'b1) begin
        bad++;
        $display("FAIL stall_cyc%0d byte%0d differs tready=%b exp=0 valid=%b exp=1", i,
                 first_diff(stall_data_q[i], exp_blk[0]), stall_rdy_q[i], stall_val_q[i]);
      end
    end
    total++;
    if (timed_out || got_blk.size() != exp_blk.size()) begin
      bad++;
      $display("FAIL stall_count got=%0d exp=%0d timeout=%0b", got_blk.size(), exp_blk.size(), timed_out);
    end
    for (int i = 0; i < got_blk.size() && i < exp_blk.size(); i++) begin
      total++;
      if (got_blk[i] !== exp_blk[i] || got_last[i] !== exp_last[i]) begin
        bad++;
        $display("FAIL stall_blk%0d byte%0d differs last=%b exp=%b", i,
                 first_diff(got_blk[i], exp_blk[i]), got_last[i], exp_last[i]);
      end
    end
    $display("backpressure: %0d stalled cycles, %0d block(s)", stall_data_q.size(), got_blk.size());
  endtask

  task automatic test_reset_mid;
    start_msg(2'd0);
    s_tvalid = 1'b1;
    s_tlast  = 1'b0;
    s_tkeep  = '1;
    s_tdata  = {8{32'($urandom)}};
    repeat (2) begin @(posedge clk); #1; end
    s_tvalid = 1'b0;
    s_tkeep  = '0;
    rst_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy_o, s_tready, blk_valid, blk_last} !== 4'b0000 || blk_data !== '0) begin
      bad++;
      $display("FAIL midrst_outputs ctrl=%b exp=0000 data_byte%0d", {busy_o, s_tready, blk_valid, blk_last},
               first_diff(blk_data, '0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    make_msg(0, 1'b1, 1'b0);
    run_message(2'd3, 0, 100, 0);
    build_model(2'd3);
    total++;
    if (timed_out || got_blk.size() != 1 || got_blk[0] !== exp_blk[0] || got_last[0] !== 1'b1) begin
      bad++;
      $display("FAIL midrst_shake256 count=%0d timeout=%0b", got_blk.size(), timed_out);
    end
    if (got_blk.size() > 0) begin
      total++;
      if (got_blk[0][7:0] !== 8'h1F || got_blk[0][135*8 +: 8] !== 8'h80) begin
        bad++;
        $display("FAIL midrst_pad byte0=%h exp=1f byte135=%h exp=80",
                 got_blk[0][7:0], got_blk[0][135*8 +: 8]);
      end
    end
    $display("reset mid-fill then shake256 empty: %0d block(s)", got_blk.size());
  endtask

  task automatic test_random;
    logic [1:0] mode;
    int len;
    for (int m = 0; m < 40; m++) begin
      mode = 2'($urandom);
      len  = $urandom_range(0, 380);
      make_msg(len, ($urandom_range(1) == 1), ($urandom_range(4) == 0));
      run_message(mode, 30, 60, 0);
      build_model(mode);
      total++;
      if (timed_out || got_blk.size() != exp_blk.size()) begin
        bad++;
        $display("FAIL rnd%0d_count got=%0d exp=%0d timeout=%0b", m, got_blk.size(), exp_blk.size(), timed_out);
      end
      for (int i = 0; i < got_blk.size() && i < exp_blk.size(); i++) begin
        total++;
        if (got_blk[i] !== exp_blk[i] || got_last[i] !== exp_last[i]) begin
          bad++;
          $display("FAIL rnd%0d_blk%0d byte%0d differs last=%b exp=%b", m, i,
                   first_diff(got_blk[i], exp_blk[i]), got_last[i], exp_last[i]);
        end
      end
      $display("random msg %0d: mode=%0d len=%0d beats=%0d blocks=%0d", m, mode, len,
               beat_q.size(), got_blk.size());
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_sha3_256_135();
    test_sha3_512_96();
    test_shake128_168();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
